// File: rtl/display_scan_driver_pkg.sv
// display_pkg: scan states, blank pattern and the hex-to-segment table
// shared by the scan driver and its decoder.
package display_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // All segments off on an active-low bus
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex digit to {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/display_scan_driver_seg_decoder.sv
// seg_decoder: combinational hex to active-low seven-segment lookup.
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: two-digit common-anode scan driver with blanking
// around every anode changeover. Optional macro DISPLAY_BRIGHTNESS_EN adds a
// 4-bit brightness input that PWM-gates the segments during SHOW.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int DIV_WIDTH    = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
`ifdef DISPLAY_BRIGHTNESS_EN
    input  logic [3:0] brightness,
`endif
    output logic       sel,
    output logic [6:0] seg,
    output logic       blank
);

    localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BCW-1:0] BC_TOGGLE = BCW'(BLANK_CYCLES - 2);
    localparam logic [BCW-1:0] BC_LAST   = BCW'(BLANK_CYCLES - 1);

    scan_state_t          r_state, w_state_nxt;
    logic [BCW-1:0]       r_bcnt, w_bcnt_nxt;
    logic [DIV_WIDTH-1:0] r_dcnt, w_dcnt_nxt;
    logic                 r_sel, w_sel_nxt;
    logic [6:0]           r_snap, w_snap_nxt;
    logic [6:0]           r_seg, w_seg_nxt;
    logic                 r_blank, w_blank_nxt;
    logic                 w_lit;
    logic [3:0]           w_snap_hex;
    logic [6:0]           w_dec_seg;

    // sel has already toggled when the snapshot is taken, so it names the
    // digit about to be powered
    assign w_snap_hex = r_sel ? digit0 : digit1;

    seg_decoder u_dec (
        .i_hex (w_snap_hex),
        .o_seg (w_dec_seg)
    );

    // Next-state and next-output logic; outputs are derived from next state
    // so every output leaves the block straight from a flop
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_dcnt_nxt  = r_dcnt;
        w_sel_nxt   = r_sel;
        w_snap_nxt  = r_snap;
        if (!enable) begin
            w_state_nxt = BLANK;
            w_bcnt_nxt  = '0;
        end else begin
            case (r_state)
                BLANK: begin
                    w_bcnt_nxt = r_bcnt + BCW'(1);
                    if (r_bcnt == BC_TOGGLE) w_sel_nxt = ~r_sel;
                    if (r_bcnt == BC_LAST) begin
                        w_state_nxt = SHOW;
                        w_bcnt_nxt  = '0;
                        w_dcnt_nxt  = '0;
                        w_snap_nxt  = w_dec_seg;
                    end
                end
                SHOW: begin
                    w_dcnt_nxt = r_dcnt + DIV_WIDTH'(1);
                    if (&r_dcnt) begin
                        w_state_nxt = BLANK;
                        w_bcnt_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = BLANK;
                    w_bcnt_nxt  = '0;
                end
            endcase
        end
        w_blank_nxt = (w_state_nxt == BLANK);
`ifdef DISPLAY_BRIGHTNESS_EN
        w_lit = (w_state_nxt == SHOW) &&
                (w_dcnt_nxt[DIV_WIDTH-1 -: 4] < brightness);
`else
        w_lit = (w_state_nxt == SHOW);
`endif
        w_seg_nxt = w_lit ? w_snap_nxt : SEG_OFF;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BLANK;
            r_bcnt  <= '0;
            r_dcnt  <= '0;
            r_sel   <= 1'b0;
            r_snap  <= SEG_OFF;
            r_seg   <= SEG_OFF;
            r_blank <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_sel   <= w_sel_nxt;
            r_snap  <= w_snap_nxt;
            r_seg   <= w_seg_nxt;
            r_blank <= w_blank_nxt;
        end
    end

    assign sel   = r_sel;
    assign seg   = r_seg;
    assign blank = r_blank;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver, DIV_WIDTH=4, BLANK_CYCLES=2.
module tb_display_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       sel;
    logic [6:0] seg;
    logic       blank;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic prev_sel = 1'b0;

    logic [6:0] tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    display_scan_driver #(.DIV_WIDTH(4), .BLANK_CYCLES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .digit0 (digit0),
        .digit1 (digit1),
        .sel    (sel),
        .seg    (seg),
        .blank  (blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for the edge where digit 1 enters SHOW
    task automatic wait_d1_show(output bit found);
        logic pb;
        found = 1'b0;
        pb = blank;
        for (int i = 0; i < 60 && !found; i++) begin
            step(1);
            if (pb && !blank && !sel) found = 1'b1;
            pb = blank;
        end
    endtask

    // Anode-change invariant: segments must be dark whenever sel moves
    always @(negedge clk) begin
        if (mon_en && (sel !== prev_sel)) chk("anode_change_dark", {1'b0, seg}, 8'h7F);
        prev_sel = sel;
    end

    initial begin
        bit found;
        reset = 1'b1; enable = 1'b1; digit0 = 4'h3; digit1 = 4'hA;
        step(2);
        chk("rst_sel", {7'b0, sel}, 8'h00);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_blank", {7'b0, blank}, 8'h01);

        // Scenario 1/2: release, digit 0 lights, mid-SHOW change ignored
        reset = 1'b0;
        step(1);                                   // edge 1
        chk("e1_sel", {7'b0, sel}, 8'h01);
        chk("e1_seg", {1'b0, seg}, 8'h7F);
        for (int e = 2; e <= 17; e++) begin
            step(1);
            chk("show0_seg", {1'b0, seg}, 8'h30);
            if (e == 2) chk("e2_blank", {7'b0, blank}, 8'h00);
            if (e == 9) digit0 = 4'h8;
        end
        step(1);                                   // edge 18
        chk("e18_seg", {1'b0, seg}, 8'h7F);
        chk("e18_blank", {7'b0, blank}, 8'h01);
        chk("e18_sel", {7'b0, sel}, 8'h01);
        step(1);                                   // edge 19
        chk("e19_seg", {1'b0, seg}, 8'h7F);
        chk("e19_sel", {7'b0, sel}, 8'h00);
        step(1);                                   // edge 20
        chk("e20_seg", {1'b0, seg}, 8'h08);
        chk("e20_blank", {7'b0, blank}, 8'h00);
        step(18);                                  // edge 38
        chk("e38_seg_new_digit0", {1'b0, seg}, 8'h00);
        chk("e38_sel", {7'b0, sel}, 8'h01);

        // Scenario 3: enable low for 5 cycles mid-SHOW
        step(2);                                   // edge 40
        enable = 1'b0;
        for (int e = 41; e <= 45; e++) begin
            step(1);
            chk("dis_seg", {1'b0, seg}, 8'h7F);
            chk("dis_sel", {7'b0, sel}, 8'h01);
            chk("dis_blank", {7'b0, blank}, 8'h01);
        end
        enable = 1'b1;
        step(1);                                   // edge 46
        chk("reen_sel", {7'b0, sel}, 8'h00);
        chk("reen_seg_dark", {1'b0, seg}, 8'h7F);
        step(1);                                   // edge 47
        chk("reen_seg_d1", {1'b0, seg}, 8'h08);
        step(3);                                   // edge 50
        chk("e50_seg", {1'b0, seg}, 8'h08);

        // Scenario 4: reset during SHOW
        reset = 1'b1;
        step(1);
        chk("mrst_sel", {7'b0, sel}, 8'h00);
        chk("mrst_seg", {1'b0, seg}, 8'h7F);
        chk("mrst_blank", {7'b0, blank}, 8'h01);
        digit0 = 4'h3;
        reset = 1'b0;
        step(1);
        chk("mrst_e1_sel", {7'b0, sel}, 8'h01);
        chk("mrst_e1_seg", {1'b0, seg}, 8'h7F);
        step(1);
        chk("mrst_e2_seg", {1'b0, seg}, 8'h30);

        // Scenario 5: sweep digit1 through all hex values
        mon_en = 1'b1;
        for (int v = 0; v < 16; v++) begin
            digit1 = 4'(v);
            wait_d1_show(found);
            chk("sweep_timeout", {7'b0, found}, 8'h01);
            chk("sweep_seg", {1'b0, seg}, {1'b0, tbl[v]});
        end
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Time-multiplexing driver for the two-digit common-anode seven-segment display.
- Generates the `sel` signal that feeds the anode-power switch: `sel=1` powers digit 0, `sel=0` powers digit 1.
- Drives the shared active-low segment bus with the hex digit for the currently powered position.
- Blanks the segments around every anode changeover so that no ghosting appears on either digit.

Parameters:
- DIV_WIDTH, 16: width of the dwell counter. Each digit is lit for 2^DIV_WIDTH cycles. Must be ≥4.
- BLANK_CYCLES, 4: segment-off cycles per changeover. Must be ≥2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  scan enable; low forces the display dark
- digit0  input  4  hex value for digit 0
- digit1  input  4  hex value for digit 1
- sel  output  1  anode select to the switch; 1 = digit 0, 0 = digit 1
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- blank  output  1  high while segments are forced off

Behaviour:
- Output timing: all outputs are registered; no combinational path from inputs to outputs.
- States: SHOW and BLANK. Counters: dcnt (DIV_WIDTH bits) and bcnt ($clog2(BLANK_CYCLES) bits).
- Reset (synchronous, takes effect on the next edge, including mid-operation):
  - state=BLANK, bcnt=0, dcnt=0, sel=0, seg=7'h7F, blank=1.
  - Reset has priority over enable.
- BLANK state:
  - seg=7'h7F, blank=1, bcnt increments each cycle.
  - When bcnt==BLANK_CYCLES-2: sel toggles on that edge.
  - When bcnt==BLANK_CYCLES-1: next state is SHOW with dcnt=0. The digit selected by the new sel (digit0 if sel=1, else digit1) is snapshotted and seg loads its decode. blank=0.
  - Net effect: segments are dark for ≥1 cycle before and ≥1 cycle after every anode change.
- SHOW state:
  - seg holds the snapshot decode. Input changes during SHOW are ignored until the next snapshot.
  - dcnt increments each cycle. When dcnt is all ones, next state is BLANK with bcnt=0, and seg=7'h7F on that edge.
  - sel is constant throughout SHOW.
- Period: per-digit period is 2^DIV_WIDTH + BLANK_CYCLES cycles. Full refresh is twice that.
- First digit after reset: the first lit digit is digit 0. sel=1 becomes visible BLANK_CYCLES-1 edges after reset release; seg becomes valid one edge later.
- enable low:
  - Next edge: state=BLANK, bcnt=0, seg=7'h7F, blank=1.
  - bcnt, dcnt and sel hold while enable is low.
  - On re-enable, the BLANK sequence runs normally: sel toggles, so the digits keep alternating.
- Decode, hex to active-low segments:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Wrap-around: dcnt wraps naturally at all ones. It never exceeds its width.

Optional Feature:
- Macro: DISPLAY_BRIGHTNESS_EN.
- When defined:
  - Adds input port `brightness` [3:0].
  - In SHOW, seg carries the snapshot decode only while dcnt[DIV_WIDTH-1 -: 4] < brightness. Otherwise seg=7'h7F.
  - blank stays 0 during these gated cycles; it reflects the scan state only.
  - brightness=0 keeps the display dark. 15 gives 15/16 duty.
  - brightness is sampled every cycle.
- When undefined: no port is added, and seg is lit for the whole of SHOW.

Decomposition:
- Package display_pkg holds:
  - state enum (SHOW, BLANK)
  - SEG_OFF = 7'h7F
  - the 16-entry hex-to-segment constant table
- Sub-module seg_decoder: a combinational 4-bit to 7-bit decoder using the package table. It is instantiated once, on the snapshot path.

Test Plan (DIV_WIDTH=4, BLANK_CYCLES=2 unless noted):
1. Reset release with digit0=3, digit1=A:
   - sel=1 at edge 1, seg=7'h30 from edge 2 to edge 17.
   - seg=7'h7F at edges 18 and 19, sel=0 at edge 19.
   - seg=7'h08 from edge 20.
2. Change digit0 from 3 to 8 mid-SHOW:
   - seg stays 7'h30 until BLANK.
   - 7'h00 appears at digit 0's next SHOW.
3. Drop enable mid-SHOW for 5 cycles:
   - Next edge gives seg=7'h7F, blank=1, and sel frozen.
   - After re-enable, sel toggles within BLANK_CYCLES-1 edges and the other digit lights.
4. Assert reset during SHOW:
   - Next edge gives sel=0, seg=7'h7F, blank=1.
   - The reset-release sequence from scenario 1 repeats.
5. Sweep all 16 hex values on digit1 and check seg against the decode table. Check the anode-switch invariant: seg==7'h7F on every cycle where sel changed.
6. With DISPLAY_BRIGHTNESS_EN defined, DIV_WIDTH=6:
   - brightness=4 gives exactly 16 lit cycles per 64-cycle SHOW.
   - brightness=0 gives zero lit cycles.
